// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: EX-stage hazard control for the 5-stage MIPS pipe. It handles
// load-use stalls, flushes on a taken branch, forwarding selects and event counters.
module ex_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rs_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             exmem_regwrite_i,
  input  logic [4:0]       exmem_rd_i,
  input  logic             exmem_branch_i,
  input  logic             exmem_zero_i,
  input  logic             memwb_regwrite_i,
  input  logic [4:0]       memwb_rd_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             idex_bubble_o,
  output logic             pc_src_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  typedef enum logic {RUN, STALL} state_t;
  localparam logic [3:0] REM_INIT = 4'(LOAD_STALL_CYCLES - 1);
  localparam bit MULTI = LOAD_STALL_CYCLES > 1;
  state_t           state_q, state_d;
  logic [3:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             load_use, br_taken, stall, flush;
  assign load_use = idex_memread_i && idex_rt_i != 5'd0 &&
                    (idex_rt_i == id_rs_i || (id_uses_rt_i && idex_rt_i == id_rt_i));
  assign br_taken = exmem_branch_i & exmem_zero_i;
  // Reset looks like a stall with no flush, so the pipe is frozen with a bubble.
  assign stall = !reset_ni || (!br_taken && (state_q == STALL || load_use));
  assign flush = reset_ni & br_taken;
  assign pc_write_o    = !stall;
  assign ifid_write_o  = !stall;
  assign idex_bubble_o = stall;
  assign pc_src_o      = flush;
  assign ifid_flush_o  = flush;
  assign idex_flush_o  = flush;
  assign exmem_flush_o = flush;
  assign fwd_a_o = !reset_ni ? 2'b00 :
                   (exmem_regwrite_i && exmem_rd_i != 5'd0 && exmem_rd_i == idex_rs_i) ? 2'b10 :
                   (memwb_regwrite_i && memwb_rd_i != 5'd0 && memwb_rd_i == idex_rs_i) ? 2'b01 : 2'b00;
  assign fwd_b_o = !reset_ni ? 2'b00 :
                   (exmem_regwrite_i && exmem_rd_i != 5'd0 && exmem_rd_i == idex_rt_i) ? 2'b10 :
                   (memwb_regwrite_i && memwb_rd_i != 5'd0 && memwb_rd_i == idex_rt_i) ? 2'b01 : 2'b00;
  always_comb begin
    state_d = br_taken ? RUN :
              state_q == STALL ? (rem_q == 4'd1 ? RUN : STALL) :
              (load_use && MULTI) ? STALL : RUN;
    rem_d   = br_taken ? 4'd0 :
              state_q == STALL ? rem_q - 4'd1 :
              (load_use && MULTI) ? REM_INIT : 4'd0;
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= RUN;
      rem_q       <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (!pc_write_o && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (br_taken && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: directed scoreboard bench; instance A (1 bubble, 2-bit counters)
// and instance B (3 bubbles, 16-bit counters) share inputs, the idle one is held in reset.
module tb_ex_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, rst_b;
  logic [4:0] id_rs, id_rt, idex_rs, idex_rt, exmem_rd, memwb_rd;
  logic id_uses_rt, memread, exmem_regwrite, branch, zero, memwb_regwrite;
  logic a_pcw, a_ifw, a_bub, a_src, a_iff, a_idf, a_exf;
  logic b_pcw, b_ifw, b_bub, b_src, b_iff, b_idf, b_exf;
  logic [1:0] a_fa, a_fb, b_fa, b_fb;
  logic [1:0] a_sc, a_fc;
  logic [15:0] b_sc, b_fc;
  ex_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(2)) dut_a (
    .clk_i(clk), .reset_ni(rst_a), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .idex_memread_i(memread), .idex_rs_i(idex_rs), .idex_rt_i(idex_rt),
    .exmem_regwrite_i(exmem_regwrite), .exmem_rd_i(exmem_rd), .exmem_branch_i(branch),
    .exmem_zero_i(zero), .memwb_regwrite_i(memwb_regwrite), .memwb_rd_i(memwb_rd),
    .pc_write_o(a_pcw), .ifid_write_o(a_ifw), .idex_bubble_o(a_bub), .pc_src_o(a_src),
    .ifid_flush_o(a_iff), .idex_flush_o(a_idf), .exmem_flush_o(a_exf),
    .fwd_a_o(a_fa), .fwd_b_o(a_fb), .stall_cnt_o(a_sc), .flush_cnt_o(a_fc));
  ex_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) dut_b (
    .clk_i(clk), .reset_ni(rst_b), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .idex_memread_i(memread), .idex_rs_i(idex_rs), .idex_rt_i(idex_rt),
    .exmem_regwrite_i(exmem_regwrite), .exmem_rd_i(exmem_rd), .exmem_branch_i(branch),
    .exmem_zero_i(zero), .memwb_regwrite_i(memwb_regwrite), .memwb_rd_i(memwb_rd),
    .pc_write_o(b_pcw), .ifid_write_o(b_ifw), .idex_bubble_o(b_bub), .pc_src_o(b_src),
    .ifid_flush_o(b_iff), .idex_flush_o(b_idf), .exmem_flush_o(b_exf),
    .fwd_a_o(b_fa), .fwd_b_o(b_fb), .stall_cnt_o(b_sc), .flush_cnt_o(b_fc));
  // ctl = {pc_write, ifid_write, idex_bubble, pc_src, ifid_flush, idex_flush, exmem_flush}
  localparam logic [6:0] NRM = 7'b1100000, STL = 7'b0010000, FLS = 7'b1101111;
  typedef struct {
    string       name;
    bit          sel;
    logic [6:0]  ctl;
    logic [3:0]  fwd;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  task automatic clr();
    id_rs = 0; id_rt = 0; idex_rs = 0; idex_rt = 0; exmem_rd = 0; memwb_rd = 0;
    id_uses_rt = 0; memread = 0; exmem_regwrite = 0; branch = 0; zero = 0; memwb_regwrite = 0;
  endtask
  task automatic cyc(input string n, input bit s, input logic [6:0] c, input logic [3:0] f,
                     input int sc, input int fc);
    exp_t e;
    e.name = n; e.sel = s; e.ctl = c; e.fwd = f; e.sc = 16'(sc); e.fc = 16'(fc);
    q.push_back(e);
    @(posedge clk); #1;
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [6:0] ctl;
      logic [3:0] fwd;
      logic [15:0] sc, fc;
      e = q.pop_front();
      ctl = e.sel ? {b_pcw, b_ifw, b_bub, b_src, b_iff, b_idf, b_exf}
                  : {a_pcw, a_ifw, a_bub, a_src, a_iff, a_idf, a_exf};
      fwd = e.sel ? {b_fa, b_fb} : {a_fa, a_fb};
      sc  = e.sel ? b_sc : {14'd0, a_sc};
      fc  = e.sel ? b_fc : {14'd0, a_fc};
      checks += 3;
      if (ctl !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got %b want %b", e.name, ctl, e.ctl);
      end
      if (fwd !== e.fwd) begin
        errors++;
        $display("FAIL %s fwd got %b want %b", e.name, fwd, e.fwd);
      end
      if (sc !== e.sc || fc !== e.fc) begin
        errors++;
        $display("FAIL %s cnt got stall=%0d flush=%0d want stall=%0d flush=%0d",
                 e.name, sc, fc, e.sc, e.fc);
      end
    end
  end
  initial begin
    clr(); rst_a = 0; rst_b = 0;
    @(posedge clk); #1;
    cyc("rst_a", 0, STL, 0, 0, 0);
    cyc("rst_b", 1, STL, 0, 0, 0);
    rst_a = 1;
    cyc("idle", 0, NRM, 0, 0, 0);
    memread = 1; idex_rt = 5; id_rs = 5;
    cyc("lu_rs", 0, STL, 0, 0, 0);
    clr();
    cyc("lu_once", 0, NRM, 0, 1, 0);
    memread = 1; idex_rt = 0; id_rs = 0;
    cyc("lu_r0", 0, NRM, 0, 1, 0);
    memread = 1; idex_rt = 9; id_rt = 9; id_rs = 3; id_uses_rt = 0;
    cyc("lu_nort", 0, NRM, 0, 1, 0);
    id_uses_rt = 1;
    cyc("lu_rt", 0, STL, 0, 1, 0);
    clr();
    cyc("lu_rt_end", 0, NRM, 0, 2, 0);
    exmem_regwrite = 1; memwb_regwrite = 1; exmem_rd = 7; memwb_rd = 7; idex_rs = 7;
    cyc("fwd_ex", 0, NRM, 4'b1000, 2, 0);
    exmem_regwrite = 0;
    cyc("fwd_wb", 0, NRM, 4'b0100, 2, 0);
    exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0;
    cyc("fwd_r0", 0, NRM, 4'b0000, 2, 0);
    exmem_rd = 4; memwb_rd = 7; idex_rs = 4; idex_rt = 7;
    cyc("fwd_ab", 0, NRM, 4'b1001, 2, 0);
    clr(); branch = 1; zero = 1;
    cyc("br_run", 0, FLS, 0, 2, 0);
    zero = 0;
    cyc("br_nt", 0, NRM, 0, 2, 1);
    zero = 1; memread = 1; idex_rt = 5; id_rs = 5;
    cyc("br_lu", 0, FLS, 0, 2, 1);
    clr();
    cyc("br_lu_end", 0, NRM, 0, 2, 2);
    memread = 1; idex_rt = 5; id_rs = 5;
    cyc("sat0", 0, STL, 0, 2, 2);
    cyc("sat1", 0, STL, 0, 3, 2);
    cyc("sat2", 0, STL, 0, 3, 2);
    cyc("sat3", 0, STL, 0, 3, 2);
    cyc("sat4", 0, STL, 0, 3, 2);
    clr();
    cyc("sat_end", 0, NRM, 0, 3, 2);
    rst_a = 0; rst_b = 1;
    cyc("b_idle", 1, NRM, 0, 0, 0);
    memread = 1; idex_rt = 10; id_rt = 10; id_uses_rt = 1;
    cyc("st3_1", 1, STL, 0, 0, 0);
    clr();
    cyc("st3_2", 1, STL, 0, 1, 0);
    cyc("st3_3", 1, STL, 0, 2, 0);
    cyc("st3_run", 1, NRM, 0, 3, 0);
    memread = 1; idex_rt = 10; id_rt = 10; id_uses_rt = 1;
    cyc("bs_1", 1, STL, 0, 3, 0);
    clr(); branch = 1; zero = 1;
    cyc("bs_br", 1, FLS, 0, 4, 0);
    clr();
    cyc("bs_run", 1, NRM, 0, 4, 1);
    cyc("bs_run2", 1, NRM, 0, 4, 1);
    memread = 1; idex_rt = 10; id_rt = 10; id_uses_rt = 1;
    cyc("rs_1", 1, STL, 0, 4, 1);
    clr(); exmem_regwrite = 1; exmem_rd = 7; idex_rs = 7; rst_b = 0;
    cyc("rs_mid", 1, STL, 0, 0, 0);
    cyc("rs_hold", 1, STL, 0, 0, 0);
    rst_b = 1;
    cyc("rs_rel", 1, NRM, 4'b1000, 0, 0);
    cyc("rs_run", 1, NRM, 4'b1000, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain queue left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
